// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that time-shares one combinational ALU
// between NUM_REQ requesters and returns each result tagged with its owner.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [DATA_WIDTH-1:0]            alu_srca,
  output logic [DATA_WIDTH-1:0]            alu_srcb,
  output logic [OPCODE_LENGTH-1:0]         alu_op,
  input  logic [DATA_WIDTH-1:0]            alu_result,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]    srca_q, srca_d, srcb_q, srcb_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;

  logic [DATA_WIDTH-1:0]    lane_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    lane_b  [NUM_REQ];
  logic [OPCODE_LENGTH-1:0] lane_op [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_a[gi]  = req_srca[gi*DATA_WIDTH +: DATA_WIDTH];
    assign lane_b[gi]  = req_srcb[gi*DATA_WIDTH +: DATA_WIDTH];
    assign lane_op[gi] = req_op[gi*OPCODE_LENGTH +: OPCODE_LENGTH];
  end

  logic [ID_W-1:0] grant;
  logic            grant_found;
  logic            accept_win;
  logic            accept;

  // First valid requester at or after ptr_q, wrapping around.
  always_comb begin : rr_search
    int idx;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant       = ID_W'(idx);
        grant_found = 1'b1;
      end
    end
  end

  // rst_n gates the window so req_ready stays low for the whole reset pulse.
  assign accept_win = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign accept     = accept_win && grant_found;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        rsp_data_d = alu_result;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      srca_d = lane_a[grant];
      srcb_d = lane_b[grant];
      op_d   = lane_op[grant];
      id_d   = grant;
      ptr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign alu_srca  = srca_q;
  assign alu_srcb  = srcb_q;
  assign alu_op    = op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a
// transaction-level model, with a behavioural ALU attached to the DUT.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int N  = 2;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_srca, req_srcb;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   lane_a [N];
  logic [DW-1:0]   lane_b [N];
  logic [OW-1:0]   lane_op [N];
  logic [DW-1:0]   alu_srca, alu_srcb, alu_result, rsp_data;
  logic [OW-1:0]   alu_op;
  logic            rsp_valid, rsp_ready, busy;
  logic [IW-1:0]   rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_srca[gi*DW +: DW] = lane_a[gi];
    assign req_srcb[gi*DW +: DW] = lane_b[gi];
    assign req_op[gi*OW +: OW]   = lane_op[gi];
  end

  // Bench-side ALU; codes outside this table return 0.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return $signed(a) >>> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_srcb, alu_op);

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  // Transaction model: one outstanding job, either executing or awaiting handshake.
  bit            m_exec, m_resp;
  int            m_ptr, m_id;
  logic [DW-1:0] m_a, m_b, m_data;
  logic [OW-1:0] m_op;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OW-1:0] op);
    req_valid[i] = v;
    lane_a[i]    = a;
    lane_b[i]    = b;
    lane_op[i]   = op;
  endtask

  task automatic model_clear();
    m_exec = 0; m_resp = 0; m_ptr = 0; m_id = 0;
    m_a = '0; m_b = '0; m_op = '0; m_data = '0;
  endtask

  // Called at a negedge with inputs already driven; checks, clocks, updates model.
  task automatic step();
    int g;
    bit win;
    logic [N-1:0] exp_ready;
    #1;
    win = !(m_exec || m_resp) || (m_resp && rsp_ready);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_ready = '0;
    if (win && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
    chk("busy", 64'(busy), 64'(m_exec || m_resp));
    chk("alu_srca", 64'(alu_srca), 64'(m_a));
    chk("alu_op", 64'(alu_op), 64'(m_op));
    if (m_resp) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
    end
    $display("cyc t=%0t valid=%b ready=%b rsp_valid=%b rsp_id=%0d rsp_data=%h",
             $time, req_valid, req_ready, rsp_valid, rsp_id, rsp_data);
    @(posedge clk);
    if (m_exec) begin
      m_exec = 0;
      m_resp = 1;
    end else begin
      if (m_resp && rsp_ready) m_resp = 0;
      if (win && g >= 0) begin
        m_a = lane_a[g]; m_b = lane_b[g]; m_op = lane_op[g];
        m_data = alu_fn(m_a, m_b, m_op);
        m_id   = g;
        m_ptr  = (g + 1) % N;
        m_exec = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_alu_srca", 64'(alu_srca), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_alt, n_rsp;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      lane_a[i] = '0; lane_b[i] = '0; lane_op[i] = '0;
    end
    do_reset();
    req_valid = '0;

    // Single ADD from requester 0
    set_lane(0, 1, 32'd5, 32'd7, 4'b0010);
    step();
    req_valid[0] = 1'b0;
    step();
    chk("add_valid", 64'(rsp_valid), 64'd1);
    chk("add_data", 64'(rsp_data), 64'd12);
    chk("add_id", 64'(rsp_id), 64'd0);
    step();
    chk("add_idle", 64'(busy), 64'd0);

    // Contention from reset: grants alternate 0,1,0
    do_reset();
    set_lane(0, 1, 32'd10, 32'd3, 4'b0110);
    set_lane(1, 1, 32'hF0, 32'h0F, 4'b0011);
    rsp_ready = 1'b1;
    exp_alt = 0;
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) begin
        chk("cont_id", 64'(rsp_id), 64'(exp_alt));
        chk("cont_data", 64'(rsp_data), (exp_alt == 1) ? 64'hFF : 64'd7);
        exp_alt ^= 1;
        n_rsp++;
      end
      step();
    end
    chk("cont_count", 64'(n_rsp), 64'd3);
    req_valid = '0;
    repeat (3) step();

    // Backpressure: SLT -1 < 1 held while rsp_ready is low
    do_reset();
    set_lane(0, 1, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    set_lane(1, 1, 32'd1, 32'd2, 4'b0010);
    rsp_ready = 1'b0;
    step();
    req_valid[0] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    step();
    step();

    // Fairness: ptr now 0; grant 0 moves it to 1, lone requester 0 still wins after wrap
    set_lane(0, 1, 32'd2, 32'd3, 4'b0010);
    step();
    req_valid = '0;
    step();
    step();
    req_valid[0] = 1'b1;
    #1;
    chk("wrap_grant", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step();
    step();
    req_valid = '1;
    #1;
    chk("ptr_after_wrap", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    step();
    step();

    // Reset in EXEC, then SRA after release
    set_lane(0, 1, 32'd1, 32'd1, 4'b0010);
    step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    do_reset();
    req_valid = '0;
    set_lane(1, 1, 32'h8000_0000, 32'd4, 4'b1000);
    step();
    req_valid = '0;
    step();
    chk("sra_valid", 64'(rsp_valid), 64'd1);
    chk("sra_data", 64'(rsp_data), 64'hF800_0000);
    chk("sra_id", 64'(rsp_id), 64'd1);
    step();

    // Undefined opcode
    set_lane(0, 1, 32'd3, 32'd4, 4'b1111);
    step();
    req_valid = '0;
    step();
    chk("undef_valid", 64'(rsp_valid), 64'd1);
    chk("undef_data", 64'(rsp_data), 64'd0);
    step();
    chk("undef_idle", 64'(busy), 64'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_lane(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("drain_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
